// File: rtl/game_status_checker.sv
// game_status_checker: scans a 4x4 exponent board one tile per clock and
// keeps sticky win/lose flags for the VGA colour stage.
module game_status_checker #(
  parameter int WIN_EXP = 11
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic [63:0] board,
  input  logic        board_valid,
  input  logic        clear,
  output logic        win,
  output logic        lose,
  output logic        busy,
  output logic        done
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [3:0] WE = 4'(WIN_EXP);
  state_t      state;
  logic [3:0]  idx;
  logic [63:0] snap;
  logic        f_win, f_empty, f_merge, pending;
  logic [3:0]  t, t_r, t_d;
  logic        fw, fe, fm;
  always_comb begin
    t   = snap[{idx, 2'b00} +: 4];
    t_r = snap[{idx + 4'd1, 2'b00} +: 4];
    t_d = snap[{idx + 4'd4, 2'b00} +: 4];
    fw  = f_win | (t == WE);
    fe  = f_empty | (t == 4'd0);
    // right/down neighbours only; the edge guards hide the wrapped indices
    fm  = f_merge | ((t != 4'd0) &&
          ((idx[1:0] != 2'd3 && t == t_r) || (idx[3:2] != 2'd3 && t == t_d)));
  end
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      f_win   <= 1'b0;
      f_empty <= 1'b0;
      f_merge <= 1'b0;
      pending <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      idx     <= '0;
      f_win   <= 1'b0;
      f_empty <= 1'b0;
      f_merge <= 1'b0;
      pending <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (board_valid) begin
          snap    <= board;
          idx     <= '0;
          f_win   <= 1'b0;
          f_empty <= 1'b0;
          f_merge <= 1'b0;
          state   <= SCAN;
          busy    <= 1'b1;
        end
      end else begin
        idx <= idx + 4'd1;
        if (idx == 4'd15) begin
          win     <= win | fw;
          lose    <= lose | (!(win | fw) & !fe & !fm);
          done    <= 1'b1;
          f_win   <= 1'b0;
          f_empty <= 1'b0;
          f_merge <= 1'b0;
          if (pending | board_valid) begin
            snap    <= board;
            pending <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          f_win   <= fw;
          f_empty <= fe;
          f_merge <= fm;
          if (board_valid) pending <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_game_status_checker.sv
// tb_game_status_checker: directed plan cases plus random boards, checked
// against a row/column board judge and a cycle-latency expectation.
module tb_game_status_checker;
  localparam int WIN_EXP = 11;
  logic        dclk = 1'b0, rst_n = 1'b0, board_valid = 1'b0, clear = 1'b0;
  logic [63:0] board = '0;
  logic        win, lose, busy, done;
  int          checks = 0, errors = 0;
  logic        mw = 1'b0, ml = 1'b0;

  game_status_checker #(.WIN_EXP(WIN_EXP)) dut (
    .dclk(dclk), .rst_n(rst_n), .board(board), .board_valid(board_valid),
    .clear(clear), .win(win), .lose(lose), .busy(busy), .done(done)
  );

  always #5 dclk = ~dclk;

  task automatic tick;
    @(posedge dclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tile(input logic [63:0] b, input int r, input int c);
    return b[(r*4 + c)*4 +: 4];
  endfunction

  // judge a whole board by the game rules, then fold into the sticky model
  task automatic commit(input logic [63:0] b);
    logic w, full, mg, nw;
    w = 1'b0; full = 1'b1; mg = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (tile(b, r, c) == 4'(WIN_EXP)) w = 1'b1;
        if (tile(b, r, c) == 4'd0) full = 1'b0;
        else begin
          if (c < 3 && tile(b, r, c) == tile(b, r, c + 1)) mg = 1'b1;
          if (r < 3 && tile(b, r, c) == tile(b, r + 1, c)) mg = 1'b1;
        end
      end
    nw = mw | w;
    ml = ml | (!nw & full & !mg);
    mw = nw;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    mw = 1'b0;
    ml = 1'b0;
  endtask

  task automatic count_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (done) cnt++;
    end
    chk(tag, 32'(cnt), 0);
  endtask

  // scan b0; if o>0, pulse board_valid with b1 at scan edge o and expect a rescan
  task automatic scan(input string tag, input logic [63:0] b0, input logic [63:0] b1, input int o);
    int lat;
    board = b0;
    board_valid = 1'b1;
    tick;
    board_valid = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (o != 0 && c == o) begin
        board = b1;
        board_valid = 1'b1;
      end
      tick;
      board_valid = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 16);
    commit(b0);
    chk({tag, "_win"}, 32'(win), 32'(mw));
    chk({tag, "_lose"}, 32'(lose), 32'(ml));
    chk({tag, "_busy1"}, 32'(busy), (o != 0) ? 1 : 0);
    if (o != 0) begin
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        tick;
        if (done) begin
          lat = c;
          break;
        end
      end
      chk({tag, "_lat2"}, 32'(lat), 16);
      commit(b1);
      chk({tag, "_win2"}, 32'(win), 32'(mw));
      chk({tag, "_lose2"}, 32'(lose), 32'(ml));
      chk({tag, "_busy2"}, 32'(busy), 0);
    end
    tick;
    chk({tag, "_pulse"}, 32'(done), 0);
  endtask

  function automatic logic [63:0] checker_board();
    logic [63:0] b;
    for (int i = 0; i < 16; i++) b[i*4 +: 4] = 4'(1 + (((i >> 2) + (i & 3)) & 1));
    return b;
  endfunction

  function automatic logic [63:0] rnd_board();
    logic [63:0] b;
    int m, p;
    m = int'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) begin
      case (m)
        0:       b[i*4 +: 4] = 4'($urandom_range(0, 15));
        1:       b[i*4 +: 4] = 4'(1 + (((i >> 2) + (i & 3)) & 1));
        2:       b[i*4 +: 4] = 4'($urandom_range(1, 4));
        default: b[i*4 +: 4] = 4'((((i >> 2) + (i & 3)) & 1) ? 5 + (i >> 3) : 8 + (i & 1));
      endcase
    end
    if ($urandom_range(0, 2) == 0) begin
      p = int'($urandom_range(0, 15));
      b[p*4 +: 4] = 4'($urandom_range(0, 15));
    end
    if ($urandom_range(0, 7) == 0) begin
      p = int'($urandom_range(0, 15));
      b[p*4 +: 4] = 4'(WIN_EXP);
    end
    return b;
  endfunction

  initial begin
    logic [63:0] cb, wb, b;
    repeat (3) tick;
    chk("rst_win", 32'(win), 0);
    chk("rst_lose", 32'(lose), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick;

    scan("zero", '0, '0, 0);
    wb = '0;
    wb[9*4 +: 4] = 4'(WIN_EXP);
    scan("win9", wb, '0, 0);
    scan("sticky", '0, '0, 0);

    cb = checker_board();
    do_clear;
    scan("chk", cb, '0, 0);
    do_clear;
    b = cb;
    b[14*4 +: 4] = 4'd3;
    b[15*4 +: 4] = 4'd3;
    scan("hpair", b, '0, 0);
    do_clear;
    b = cb;
    b[11*4 +: 4] = 4'd3;
    b[15*4 +: 4] = 4'd3;
    scan("vpair", b, '0, 0);

    do_clear;
    scan("pend", cb, wb, 5);
    count_done("pend_extra", 20);

    // clear mid-scan while win is set
    board = '0;
    board_valid = 1'b1;
    tick;
    board_valid = 1'b0;
    repeat (5) tick;
    do_clear;
    chk("clr_win", 32'(win), 0);
    chk("clr_busy", 32'(busy), 0);
    count_done("clr_nodone", 20);

    // reset pulse at scan cycle 8
    scan("prewin", wb, '0, 0);
    board = cb;
    board_valid = 1'b1;
    tick;
    board_valid = 1'b0;
    repeat (7) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mw = 1'b0;
    ml = 1'b0;
    chk("rst2_win", 32'(win), 0);
    chk("rst2_lose", 32'(lose), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_done", 32'(done), 0);
    count_done("rst2_nodone", 20);
    scan("after_rst", cb, '0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) do_clear;
      scan("rnd", rnd_board(), rnd_board(),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
